// File: rtl/hdmi_rd_timing_if.sv
// Video/read-path bundle between the HDMI timing generator and its neighbours.
//   init_calib_complete : DDR3 calibration done (ui_clk domain, resynchronised by the master)
//   rd_load             : frame-start marker towards the DDR3 read side
//   rdata_req           : read-FIFO read enable, one 16-bit pixel per cycle
//   dataout             : read-FIFO data, RGB565, valid the cycle after rdata_req
//   video_hs/vs/de      : sync and active-video strobes, active high
//   video_rgb           : RGB888 pixel, black when video_de is low
// master = timing generator, slave = FIFO/encoder side.
interface hdmi_rd_timing_if;
    logic        init_calib_complete;
    logic        rd_load;
    logic        rdata_req;
    logic [15:0] dataout;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic [23:0] video_rgb;

    modport master (
        input  init_calib_complete,
        input  dataout,
        output rd_load,
        output rdata_req,
        output video_hs,
        output video_vs,
        output video_de,
        output video_rgb
    );

    modport slave (
        output init_calib_complete,
        output dataout,
        input  rd_load,
        input  rdata_req,
        input  video_hs,
        input  video_vs,
        input  video_de,
        input  video_rgb
    );
endinterface

// File: rtl/hdmi_rd_timing.sv
// HDMI-side video timing generator and DDR3 read-FIFO master.
// Free-running h/v counters produce hsync/vsync/de; once DDR3 calibration is
// seen (and only from a frame boundary) pixels are requested from the read FIFO,
// expanded RGB565 -> RGB888 and presented aligned with video_de.
// Ports:
//   pixel_clk : pixel clock, all logic on the rising edge
//   sys_rst_n : asynchronous active-low reset
//   vid       : hdmi_rd_timing_if.master (calib in, FIFO data in, timing/pixel out)
// Every video output lags the counters by three pixel clocks.
module hdmi_rd_timing #(
    parameter int unsigned H_SYNC  = 40,
    parameter int unsigned H_BACK  = 220,
    parameter int unsigned H_DISP  = 1280,
    parameter int unsigned H_FRONT = 110,
    parameter int unsigned V_SYNC  = 5,
    parameter int unsigned V_BACK  = 20,
    parameter int unsigned V_DISP  = 720,
    parameter int unsigned V_FRONT = 5
) (
    input  logic              pixel_clk,
    input  logic              sys_rst_n,
    hdmi_rd_timing_if.master  vid
);

    localparam int unsigned H_TOTAL   = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL   = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned HW        = $clog2(H_TOTAL);
    localparam int unsigned VW        = $clog2(V_TOTAL);
    localparam int unsigned H_ACT_BEG = H_SYNC + H_BACK;
    localparam int unsigned H_ACT_END = H_SYNC + H_BACK + H_DISP;
    localparam int unsigned V_ACT_BEG = V_SYNC + V_BACK;
    localparam int unsigned V_ACT_END = V_SYNC + V_BACK + V_DISP;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          hs0;
    logic          vs0;
    logic          act0;

    logic          calib_meta;
    logic          calib_sync;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          run;

    logic          rd_load_q;
    logic          rdata_req_q;
    logic          hs1, vs1, de1;
    logic          hs2, vs2, de2, req2;
    logic          video_hs_q, video_vs_q, video_de_q;
    logic [23:0]   video_rgb_q;
    logic [23:0]   rgb888;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    // Raster counters, free running from reset release regardless of state
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Stage-0 timing windows decoded straight from the counters
    assign hs0  = (h_cnt < HW'(H_SYNC));
    assign vs0  = (v_cnt < VW'(V_SYNC));
    assign act0 = (h_cnt >= HW'(H_ACT_BEG)) && (h_cnt < HW'(H_ACT_END)) &&
                  (v_cnt >= VW'(V_ACT_BEG)) && (v_cnt < VW'(V_ACT_END));

    // Two-flop resynchroniser for the ui_clk-domain calibration flag
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            calib_meta <= 1'b0;
            calib_sync <= 1'b0;
        end else begin
            calib_meta <= vid.init_calib_complete;
            calib_sync <= calib_meta;
        end
    end

    // State register
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: reads only start on a frame boundary; losing calib aborts at once
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (calib_sync) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!calib_sync)          state_nxt = ST_IDLE;
                else if (h_last && v_last) state_nxt = ST_RUN;
            end
            ST_RUN:  if (!calib_sync) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign run = (state == ST_RUN);

    // RGB565 -> RGB888 by replicating each component's MSBs into the new LSBs
    assign rgb888 = {vid.dataout[15:11], vid.dataout[15:13],
                     vid.dataout[10:5],  vid.dataout[10:9],
                     vid.dataout[4:0],   vid.dataout[4:2]};

    // Request stage, two alignment stages, then registered video outputs
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_load_q   <= 1'b0;
            rdata_req_q <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            de1         <= 1'b0;
            hs2         <= 1'b0;
            vs2         <= 1'b0;
            de2         <= 1'b0;
            req2        <= 1'b0;
            video_hs_q  <= 1'b0;
            video_vs_q  <= 1'b0;
            video_de_q  <= 1'b0;
            video_rgb_q <= '0;
        end else begin
            rd_load_q   <= run && vs0;
            rdata_req_q <= run && act0;
            hs1         <= hs0;
            vs1         <= vs0;
            de1         <= act0;
            hs2         <= hs1;
            vs2         <= vs1;
            de2         <= de1;
            req2        <= rdata_req_q;
            video_hs_q  <= hs2;
            video_vs_q  <= vs2;
            video_de_q  <= de2;
            // FIFO data is only meaningful in the cycle after an issued request
            video_rgb_q <= (de2 && req2) ? rgb888 : 24'h0;
        end
    end

    assign vid.rd_load   = rd_load_q;
    assign vid.rdata_req = rdata_req_q;
    assign vid.video_hs  = video_hs_q;
    assign vid.video_vs  = video_vs_q;
    assign vid.video_de  = video_de_q;
    assign vid.video_rgb = video_rgb_q;

endmodule

// File: tb/tb_hdmi_rd_timing.sv
// Scoreboard bench for hdmi_rd_timing on the reduced raster (H 2/2/8/2, V 1/1/4/1).
module tb_hdmi_rd_timing;

    localparam int HT   = 14;
    localparam int VT   = 7;
    localparam int MAXN = 1024;

    typedef struct packed {
        logic        rd_load;
        logic        rdata_req;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    hdmi_rd_timing_if vif();

    hdmi_rd_timing #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1)
    ) dut (
        .pixel_clk (clk),
        .sys_rst_n (rst_n),
        .vid       (vif)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          n;
    bit          calib_h [MAXN];
    bit          run_h   [MAXN];
    bit          req_e   [MAXN];
    logic [15:0] data_h  [MAXN];
    int          st_h    [MAXN];
    bit          req_prev;
    int          pix_idx = 0;
    int          cnt_req = 0, cnt_load = 0;
    int          first_req_n = -1, first_load_n = -1, first_req2_n = -1;
    logic [23:0] cap [4];
    int          cap_n = 0;
    logic [15:0] pix_tab [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410};

    function automatic int hc(input int k); return k % HT; endfunction
    function automatic int vc(input int k); return (k / HT) % VT; endfunction
    function automatic bit hs0(input int k); return hc(k) < 2; endfunction
    function automatic bit vs0(input int k); return vc(k) < 1; endfunction
    function automatic bit act0(input int k);
        return hc(k) >= 4 && hc(k) < 12 && vc(k) >= 2 && vc(k) < 6;
    endfunction

    // Hand-expanded RGB888 for every value the FIFO model can present
    function automatic logic [23:0] conv(input logic [15:0] d);
        case (d)
            16'hF800: return 24'hFF0000;
            16'h07E0: return 24'h00FF00;
            16'h001F: return 24'h0000FF;
            16'h8410: return 24'h848284;
            16'hFFFF: return 24'hFFFFFF;
            default:  return 24'h000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s n=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return 32'({vif.rd_load, vif.rdata_req, vif.video_hs, vif.video_vs,
                    vif.video_de, vif.video_rgb});
    endfunction

    task automatic seg_start(input bit cal);
        n          = 0;
        calib_h[0] = cal;
        run_h[0]   = 1'b0;
        req_e[0]   = 1'b0;
        data_h[0]  = 16'hFFFF;
        st_h[0]    = 0;
        req_prev   = 1'b0;
    endtask

    // One pixel clock: drive inputs, advance the reference, queue the expectation
    task automatic step(input bit cal);
        exp_t e;
        bit   sync_prev;
        @(posedge clk);
        #1;
        n++;
        vif.init_calib_complete = cal;
        if (req_prev) begin
            vif.dataout = pix_tab[pix_idx % 4];
            pix_idx++;
        end else begin
            vif.dataout = 16'hFFFF;
        end
        req_prev   = vif.rdata_req;
        calib_h[n] = cal;
        data_h[n]  = vif.dataout;
        sync_prev  = (n >= 3) ? calib_h[n-3] : 1'b0;
        case (st_h[n-1])
            0:       st_h[n] = sync_prev ? 1 : 0;
            1:       st_h[n] = !sync_prev ? 0 :
                               ((hc(n-1) == HT-1 && vc(n-1) == VT-1) ? 2 : 1);
            default: st_h[n] = sync_prev ? 2 : 0;
        endcase
        run_h[n]    = (st_h[n] == 2);
        e.rd_load   = run_h[n-1] && vs0(n-1);
        e.rdata_req = run_h[n-1] && act0(n-1);
        req_e[n]    = e.rdata_req;
        e.hs        = (n >= 3) ? hs0(n-3)  : 1'b0;
        e.vs        = (n >= 3) ? vs0(n-3)  : 1'b0;
        e.de        = (n >= 3) ? act0(n-3) : 1'b0;
        e.rgb       = (n >= 2 && req_e[n-2]) ? conv(data_h[n-1]) : 24'h0;
        q.push_back(e);
        if (vif.rdata_req) begin
            cnt_req++;
            if (first_req_n < 0) first_req_n = n;
            if (n > 640 && first_req2_n < 0) first_req2_n = n;
        end
        if (vif.rd_load) begin
            cnt_load++;
            if (first_load_n < 0) first_load_n = n;
        end
        if (vif.video_rgb != 24'h0 && cap_n < 4) begin
            cap[cap_n] = vif.video_rgb;
            cap_n++;
        end
    endtask

    // Monitor: compare every presented output cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                check("cycle_outputs", dut_outs(), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog n=%0d actual=running required=finished", n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vif.init_calib_complete = 1'b0;
        vif.dataout             = 16'hFFFF;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", dut_outs(), 32'h0);
        rst_n = 1'b1;
        seg_start(1'b0);

        // Uncalibrated for three frames, then calib rises at v=3 and RUN covers two frames
        while (n < 588) step((n + 1) >= 336);
        check("req_count_2frames",  32'(cnt_req),      32'd64);
        check("load_count_2frames", 32'(cnt_load),     32'd28);
        check("first_req_cycle",    32'(first_req_n),  32'd425);
        check("first_load_cycle",   32'(first_load_n), 32'd393);
        check("first_rgb0", 32'(cap[0]), 32'h00FF0000);
        check("first_rgb1", 32'(cap[1]), 32'h0000FF00);
        check("first_rgb2", 32'(cap[2]), 32'h000000FF);
        check("first_rgb3", 32'(cap[3]), 32'h00848284);

        // Calib lost at the third pixel of line 3, back up, glitched once while in WAIT
        while (n < 738) begin
            int k;
            k = n + 1;
            step(!((k >= 636 && k <= 660) || k == 670));
            case (n)
                639: check("req_last_pixel", 32'(vif.rdata_req), 32'd1);
                640: check("req_dropped",    32'(vif.rdata_req), 32'd0);
                641: check("rgb_draining",   32'(vif.video_rgb != 24'h0), 32'd1);
                642: begin
                    check("rgb_black", 32'(vif.video_rgb), 32'd0);
                    check("de_kept",   32'(vif.video_de),  32'd1);
                end
                default: ;
            endcase
        end
        check("rerun_first_req", 32'(first_req2_n), 32'd719);

        // Asynchronous reset in the middle of an active line
        #4 rst_n = 1'b0;
        #1 check("async_reset_outputs", dut_outs(), 32'h0);
        repeat (3) @(negedge clk);
        vif.dataout = 16'hFFFF;
        rst_n = 1'b1;
        seg_start(1'b1);
        first_req_n = -1;
        while (n < 140) step(1'b1);
        check("post_reset_first_req", 32'(first_req_n), 32'd131);

        @(posedge clk);
        #3;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
